// File: rtl/rll_seq_core.sv
// rtl/rll_seq_core.sv - serially keyed XOR/XNOR gate in front of an elastic STAGES-deep data pipeline
module rll_seq_core #(
    parameter int              DATA_W   = 32,
    parameter int              KEY_W    = 32,
    parameter int              STAGES   = 2,
    parameter logic [KEY_W-1:0] POLARITY = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_start,
    input  logic              key_shift,
    input  logic              key_sdi,
    output logic              key_armed,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);
    localparam int CW  = $clog2(KEY_W + 1);
    localparam int REP = DATA_W / KEY_W;
    localparam logic [CW-1:0] LAST_CNT = CW'(KEY_W - 1);

    if (DATA_W % KEY_W != 0) begin : g_bad_width
        $error("DATA_W must be an integer multiple of KEY_W");
    end
    if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
        $error("STAGES must be in 1..8");
    end

    typedef enum logic [1:0] {IDLE, SHIFT, ARMED} state_t;

    state_t            state, state_nx;
    logic [KEY_W-1:0]  key_reg;
    logic [CW-1:0]     shift_cnt;
    logic              shift_acc;
    logic              last_shift;

    // A shift coinciding with key_start belongs to the aborted load and is dropped.
    assign shift_acc  = (state == SHIFT) && key_shift && !key_start;
    assign last_shift = shift_acc && (shift_cnt == LAST_CNT);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (key_start) state_nx = SHIFT;
            SHIFT:   if (key_start) state_nx = SHIFT;
                     else if (last_shift) state_nx = ARMED;
            ARMED:   if (key_start) state_nx = SHIFT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            key_reg   <= '0;
            shift_cnt <= '0;
        end else begin
            state <= state_nx;
            if (key_start) begin
                shift_cnt <= '0;
            end else if (shift_acc) begin
                key_reg   <= {key_sdi, key_reg[KEY_W-1:1]};
                shift_cnt <= shift_cnt + 1'b1;
            end
        end
    end

    assign key_armed = (state == ARMED);

    logic [STAGES-1:0] stg_valid;
    logic [STAGES-1:0] stg_adv;
    logic [DATA_W-1:0] stg_data [STAGES];
    logic              s0_free;
    logic              in_fire;
    logic [DATA_W-1:0] key_mask;

    assign key_mask = {REP{key_reg ^ POLARITY}};

    // Backpressure ripples from the output toward stage 0 within one cycle.
    always_comb begin
        logic rdy;
        rdy     = out_ready;
        stg_adv = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            stg_adv[k] = stg_valid[k] && rdy;
            rdy        = !stg_valid[k] || rdy;
        end
        s0_free = rdy;
    end

    assign in_ready = key_armed && s0_free;
    assign in_fire  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_valid <= '0;
            for (int k = 0; k < STAGES; k++) stg_data[k] <= '0;
        end else begin
            if (in_fire) begin
                stg_valid[0] <= 1'b1;
                stg_data[0]  <= in_data ^ key_mask;
            end else if (stg_adv[0]) begin
                stg_valid[0] <= 1'b0;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (stg_adv[k-1]) begin
                    stg_valid[k] <= 1'b1;
                    stg_data[k]  <= stg_data[k-1];
                end else if (stg_adv[k]) begin
                    stg_valid[k] <= 1'b0;
                end
            end
        end
    end

    assign out_valid = stg_valid[STAGES-1];
    assign out_data  = stg_data[STAGES-1];
endmodule

// File: tb/tb_rll_seq_core.sv
// tb/tb_rll_seq_core.sv - directed/random bench with a word-queue key model for rll_seq_core
module tb_rll_seq_core;
    localparam logic [31:0] POL_A = 32'hA5A5_0F0F;
    localparam logic [15:0] POL_B = 16'h00FF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        key_start = 0, key_shift = 0, key_sdi = 0;
    logic        key_armed, in_ready, out_valid;
    logic        in_valid = 0, out_ready = 1;
    logic [31:0] in_data = '0, out_data;

    logic        b_key_start = 0, b_key_shift = 0, b_key_sdi = 0;
    logic        b_key_armed, b_in_ready, b_out_valid;
    logic        b_in_valid = 0, b_out_ready = 1;
    logic [63:0] b_in_data = '0, b_out_data;

    rll_seq_core #(.DATA_W(32), .KEY_W(32), .STAGES(2), .POLARITY(POL_A)) dut_a (
        .clk(clk), .rst(rst), .key_start(key_start), .key_shift(key_shift), .key_sdi(key_sdi),
        .key_armed(key_armed), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data));

    rll_seq_core #(.DATA_W(64), .KEY_W(16), .STAGES(1), .POLARITY(POL_B)) dut_b (
        .clk(clk), .rst(rst), .key_start(b_key_start), .key_shift(b_key_shift), .key_sdi(b_key_sdi),
        .key_armed(b_key_armed), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data));

    int          n_chk = 0, n_err = 0;
    int          n_acc = 0, n_out = 0;
    logic [31:0] model_key = '0;
    logic        exp_armed = 0;
    logic [31:0] exp_q[$];
    logic        accepted;
    logic        held = 0;
    logic [31:0] held_d;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes mid-cycle, update the model, return just after the edge.
    task automatic cyc();
        @(negedge clk);
        accepted = 1'b0;
        if (!exp_armed) chk("in_ready_unarmed", in_ready, 0);
        if (held) chk("stall_hold", {out_valid, out_data}, {1'b1, held_d});
        held   = out_valid && !out_ready && !rst;
        held_d = out_data;
        if (!rst && out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
            else chk("out_data", out_data, exp_q.pop_front());
        end
        if (!rst && in_valid && in_ready) begin
            exp_q.push_back(in_data ^ (model_key ^ POL_A));
            n_acc++;
            accepted = 1'b1;
        end
        @(posedge clk);
        #1;
        if (rst) exp_q.delete();
    endtask

    task automatic shift_n(input logic [31:0] v, input int n, input bit chk_arm);
        for (int i = 0; i < n; i++) begin
            key_shift = 0;
            repeat ($urandom_range(0, 1)) cyc();
            key_shift = 1;
            key_sdi   = v[i];
            cyc();
            if (chk_arm) chk($sformatf("armed_after_shift%0d", i + 1), key_armed, (i == 31));
        end
        key_shift = 0;
    endtask

    task automatic key_restart();
        key_start = 1;
        key_shift = 1;
        key_sdi   = $urandom;
        cyc();
        key_start = 0;
        key_shift = 0;
        exp_armed = 0;
    endtask

    task automatic load_key(input logic [31:0] v);
        key_restart();
        shift_n(v, 32, 1'b1);
        model_key = v;
        exp_armed = 1;
    endtask

    task automatic send_one(input logic [31:0] w);
        in_valid = 1;
        in_data  = w;
        for (int t = 0; t < 20; t++) begin
            cyc();
            if (accepted) break;
        end
        chk("send_accepted", accepted, 1);
        in_valid = 0;
    endtask

    task automatic drain();
        out_ready = 1;
        for (int t = 0; t < 20 && exp_q.size() != 0; t++) cyc();
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic b_load(input logic [15:0] v);
        b_key_start = 1;
        @(posedge clk); #1;
        b_key_start = 0;
        for (int i = 0; i < 16; i++) begin
            b_key_shift = 1;
            b_key_sdi   = v[i];
            @(posedge clk); #1;
        end
        b_key_shift = 0;
        chk("b_armed", b_key_armed, 1);
    endtask

    task automatic b_send(input logic [15:0] key, output logic [63:0] got, output logic [63:0] sent);
        sent        = {$urandom, $urandom};
        b_in_data   = sent;
        b_in_valid  = 1;
        b_out_ready = 1;
        chk("b_in_ready", b_in_ready, 1);
        @(posedge clk); #1;
        b_in_valid = 0;
        chk("b_latency1_valid", b_out_valid, 1);
        chk("b_out_data", b_out_data, sent ^ {4{key ^ POL_B}});
        got = b_out_data;
        @(posedge clk); #1;
    endtask

    initial begin : main
        logic        saw_block;
        int          sent;
        logic [31:0] w;
        logic [63:0] bg, bs;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_armed", key_armed, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        rst = 0;

        // correct key: passthrough with 2-cycle latency
        load_key(32'hA5A5_0F0F);
        in_valid = 1;
        in_data  = 32'h1234_5678;
        chk("first_in_ready", in_ready, 1);
        cyc();
        in_valid = 0;
        chk("lat_c1_valid", out_valid, 0);
        cyc();
        chk("lat_c2_valid", out_valid, 1);
        chk("lat_c2_data", out_data, 32'h1234_5678);
        cyc();

        load_key(32'h0000_0000);
        send_one(32'hFFFF_FFFF);
        cyc();
        chk("zero_key_data", out_data, 32'h5A5A_F0F0);
        drain();

        // shifts while armed are ignored
        key_shift = 1;
        repeat (5) begin key_sdi = $urandom; cyc(); end
        key_shift = 0;
        send_one($urandom);
        drain();

        // back-to-back stream with output stall
        load_key($urandom);
        saw_block = 0;
        sent      = 0;
        w         = $urandom;
        for (int c = 0; c < 40 && sent < 8; c++) begin
            in_valid  = 1;
            in_data   = w;
            out_ready = !(c >= 3 && c <= 5);
            if (c == 4) chk("stall_in_ready", in_ready, 0);
            if (!in_ready) saw_block = 1;
            cyc();
            if (accepted) begin sent++; w = $urandom; end
        end
        in_valid = 0;
        chk("stream_sent", sent, 8);
        chk("stream_blocked", saw_block, 1);
        drain();

        // restart mid-load, in-flight words drain under the old key
        out_ready = 0;
        send_one($urandom);
        send_one($urandom);
        out_ready = 1;
        key_restart();
        shift_n($urandom, 10, 1'b0);
        load_key(POL_A);
        drain();
        for (int i = 0; i < 12; i++) begin
            in_valid  = 1;
            in_data   = $urandom;
            out_ready = $urandom_range(0, 1);
            cyc();
        end
        in_valid = 0;
        drain();

        // reset with words in flight
        out_ready = 0;
        send_one($urandom);
        send_one($urandom);
        rst = 1;
        cyc();
        exp_armed = 0;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_armed", key_armed, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_out_data", out_data, 0);
        n_acc -= 2;
        rst = 0;
        out_ready = 1;
        load_key($urandom);
        send_one($urandom);
        drain();
        chk("word_conservation", n_out, n_acc);

        // 64/16/1 configuration
        b_load(POL_B);
        b_send(POL_B, bg, bs);
        chk("b_passthrough", bg, bs);
        b_load(POL_B ^ 16'h0001);
        b_send(POL_B ^ 16'h0001, bg, bs);
        chk("b_bit0_flip", bg ^ bs, 64'h0001_0001_0001_0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/rll_seq_core.md
RLL_SEQ_CORE -- requirements
Module: rll_seq_core

Interface
REQ-001 Parameter DATA_W, default 32, data path width in bits.
REQ-002 Parameter KEY_W, default 32, key register width; DATA_W SHALL be an integer multiple of KEY_W (elaboration error otherwise).
REQ-003 Parameter STAGES, default 2, pipeline depth, legal range 1..8.
REQ-004 Parameter POLARITY, default all-zero KEY_W-bit constant, key-gate type per bit: 0 = XOR gate, 1 = XNOR gate.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 key_start  input  1  one-cycle pulse; begins a new key load.
REQ-008 key_shift  input  1  qualifies key_sdi for one shift.
REQ-009 key_sdi  input  1  serial key bit.
REQ-010 key_armed  output  1  high when a full key is loaded and the data path accepts input.
REQ-011 in_valid  input  1, in_ready  output  1, in_data  input  DATA_W  (input handshake).
REQ-012 out_valid  output  1, out_ready  input  1, out_data  output  DATA_W  (output handshake).

Function
REQ-013 FSM states: IDLE, SHIFT, ARMED; state SHALL be IDLE after reset.
REQ-014 IDLE -> SHIFT on key_start; SHIFT -> ARMED on the cycle the KEY_W-th accepted shift occurs; ARMED -> SHIFT on key_start.
REQ-015 key_start in SHIFT SHALL restart the load: counter cleared, state remains SHIFT, key_reg retained until overwritten.
REQ-016 On key_start, a key_shift in the same cycle SHALL be ignored.
REQ-017 In SHIFT with key_shift=1: key_reg <= {key_sdi, key_reg[KEY_W-1:1]}; shift counter (width clog2(KEY_W+1)) increments.
REQ-018 key_shift outside SHIFT SHALL be ignored; key_reg is unchanged.
REQ-019 key_armed = (state == ARMED), registered.
REQ-020 Effective key E = key_reg XOR POLARITY; data bit j SHALL be gated by E[j mod KEY_W].
REQ-021 Stage-1 register SHALL capture in_data XOR replicated E on input handshake; later stages copy unchanged.
REQ-022 out_data = last-stage register; correct key (key_reg == POLARITY) therefore yields out_data == in_data.
REQ-023 in_ready = key_armed AND (stage 1 empty OR stage 1 advancing); in_ready SHALL be 0 in IDLE and SHIFT.
REQ-024 Stage k advances when valid and (stage k+1 empty or advancing); last stage advances on out_valid AND out_ready.
REQ-025 Latency: STAGES cycles from accepted input to out_valid with out_ready held high; throughput 1 word/cycle.
REQ-026 out_valid/out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-027 Words already in the pipeline when key_start arrives SHALL drain with the key applied at acceptance; no data is dropped or duplicated.
REQ-028 No output SHALL reveal key_reg or a key-correctness indication.

Reset
REQ-029 rst=1 at a clock edge SHALL set state IDLE, key_reg 0, counter 0, all stage valids 0; overriding any simultaneous key_start/key_shift/handshake.
REQ-030 Output values during/after reset: key_armed 0, in_ready 0, out_valid 0, out_data 0.
REQ-031 Reset mid-load or mid-stream SHALL discard the partial key and all in-flight words.

Verification (DATA_W=32, KEY_W=32, STAGES=2, POLARITY=32'hA5A5_0F0F)
REQ-032 Load 32'hA5A5_0F0F LSB-first, send 32'h1234_5678 with out_ready=1 -> key_armed high after 32nd shift; out_data 32'h1234_5678 exactly 2 cycles after acceptance.
REQ-033 Load 32'h0000_0000, send 32'hFFFF_FFFF -> out_data 32'h5A5A_F0F0.
REQ-034 Stream 8 words back-to-back, out_ready low for cycles 3-5 -> in_ready drops once both stages are full, no loss/duplication, out_data held stable while stalled, order preserved.
REQ-035 key_start after 10 shifts, then 32 shifts of the correct key -> armed only after the 32 post-restart shifts; in_ready 0 throughout.
REQ-036 rst asserted with 2 words in flight and key armed -> next cycle out_valid 0, key_armed 0, in_ready 0; first 31 post-reload shifts leave key_armed 0.
REQ-037 Parameter sweep DATA_W=64, KEY_W=16, STAGES=1, POLARITY=16'h00FF, correct key -> out_data == in_data with 1-cycle latency; wrong key bit 0 flipped -> data bits 0, 16, 32, 48 inverted.
